// File: rtl/imem_load_fetch_ctrl.sv
// imem_load_fetch_ctrl: arbitrates the shared address/write port of four
// byte-lane instruction memories between a byte-serial program loader and
// the instruction fetch stage. The loader owns the port while a load runs.
module imem_load_fetch_ctrl #(
   parameter int          ADDR_W    = 8,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_start,
   input  logic [ADDR_W:0]   load_words,
   input  logic              load_valid,
   input  logic [7:0]        load_data,
   output logic              load_ready,
   output logic              load_done,
   output logic              busy,
   input  logic              fetch_req,
   input  logic [31:0]       fetch_pc,
   output logic              fetch_valid,
   output logic [31:0]       fetch_instr,
   output logic              fetch_misalign,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_we,
   output logic [7:0]        mem_wdata,
   input  logic [31:0]       mem_rdata
);

   // DEPTH expressed in the width of load_words, used for clamping
   localparam logic [ADDR_W:0] DEPTH_W = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] ONE_W   = {{ADDR_W{1'b0}}, 1'b1};

   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

   state_t              state;
   logic [1:0]          lane_cnt;
   logic [ADDR_W-1:0]   word_cnt;
   logic [ADDR_W-1:0]   last_word;
   logic [ADDR_W:0]     words_clamped;
   logic [ADDR_W:0]     words_m1;
   logic                accept;
   logic                misalign;

   assign words_clamped = (load_words > DEPTH_W) ? DEPTH_W : load_words;
   assign words_m1      = words_clamped - ONE_W;
   assign accept        = (state == LOAD) && load_valid;
   assign misalign      = (fetch_pc[1:0] != 2'b00);

   // Port mux: fetch PC drives the address in IDLE, the load word counter otherwise
   always_comb begin
      mem_addr  = word_cnt;
      mem_we    = 4'b0000;
      mem_wdata = 8'h00;
      if (state == IDLE) begin
         mem_addr = fetch_pc[ADDR_W+1:2];
      end
      if (accept) begin
         mem_we    = 4'b0001 << lane_cnt;
         mem_wdata = load_data;
      end
   end

   // Load FSM with registered status outputs; the last word index is latched at start
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         lane_cnt   <= 2'd0;
         word_cnt   <= '0;
         last_word  <= '0;
         load_ready <= 1'b0;
         load_done  <= 1'b0;
         busy       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (load_start) begin
                  busy      <= 1'b1;
                  last_word <= words_m1[ADDR_W-1:0];
                  if (load_words == '0) begin
                     state     <= DONE;
                     load_done <= 1'b1;
                  end else begin
                     state      <= LOAD;
                     load_ready <= 1'b1;
                  end
               end
            end
            LOAD: begin
               if (accept) begin
                  lane_cnt <= lane_cnt + 2'd1;
                  if (lane_cnt == 2'd3) begin
                     word_cnt <= word_cnt + ADDR_W'(1);
                     if (word_cnt == last_word) begin
                        state      <= DONE;
                        load_ready <= 1'b0;
                        load_done  <= 1'b1;
                     end
                  end
               end
            end
            DONE: begin
               state     <= IDLE;
               load_done <= 1'b0;
               busy      <= 1'b0;
               lane_cnt  <= 2'd0;
               word_cnt  <= '0;
            end
            default: begin
               state      <= IDLE;
               load_ready <= 1'b0;
               load_done  <= 1'b0;
               busy       <= 1'b0;
            end
         endcase
      end
   end

   // Fetch response register: one cycle latency, dropped when a load starts
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_valid    <= 1'b0;
         fetch_instr    <= 32'h0;
         fetch_misalign <= 1'b0;
      end else begin
         fetch_valid <= 1'b0;
         if ((state == IDLE) && fetch_req && !load_start) begin
            fetch_valid    <= 1'b1;
            fetch_misalign <= misalign;
            fetch_instr    <= misalign ? NOP_INSTR : mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_imem_load_fetch_ctrl.sv
// tb_imem_load_fetch_ctrl: random loads and fetches against a word-array
// reference of the instruction memory; byte k of a load lands in word k/4, lane k%4.
module tb_imem_load_fetch_ctrl;

   localparam int          AW    = 8;
   localparam int          DEPTH = 256;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          load_start;
   logic [AW:0]   load_words;
   logic          load_valid;
   logic [7:0]    load_data;
   logic          load_ready;
   logic          load_done;
   logic          busy;
   logic          fetch_req;
   logic [31:0]   fetch_pc;
   logic          fetch_valid;
   logic [31:0]   fetch_instr;
   logic          fetch_misalign;
   logic [AW-1:0] mem_addr;
   logic [3:0]    mem_we;
   logic [7:0]    mem_wdata;
   logic [31:0]   mem_rdata;

   imem_load_fetch_ctrl #(.ADDR_W(AW), .NOP_INSTR(NOP)) dut (
      .clk(clk), .rst_n(rst_n),
      .load_start(load_start), .load_words(load_words),
      .load_valid(load_valid), .load_data(load_data),
      .load_ready(load_ready), .load_done(load_done), .busy(busy),
      .fetch_req(fetch_req), .fetch_pc(fetch_pc),
      .fetch_valid(fetch_valid), .fetch_instr(fetch_instr),
      .fetch_misalign(fetch_misalign),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // byte-lane memories: combinational read, synchronous write
   logic [7:0] bmem [4][DEPTH];
   assign mem_rdata = {bmem[3][mem_addr], bmem[2][mem_addr], bmem[1][mem_addr], bmem[0][mem_addr]};
   always @(posedge clk) begin
      for (int n = 0; n < 4; n++)
         if (mem_we[n]) bmem[n][mem_addr] <= mem_wdata;
   end

   logic [31:0] ref_mem [DEPTH];
   logic [31:0] last_instr;
   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // one IDLE cycle with or without a fetch request; stray loader bytes must be refused
   task automatic do_fetch(input logic [31:0] pc, input bit req);
      int w;
      fetch_req  = req;
      fetch_pc   = pc;
      load_start = 1'b0;
      load_valid = 1'($urandom);
      load_data  = 8'($urandom);
      w = int'(pc[9:2]);
      #1;
      chk("idle_we", 32'(mem_we), 32'h0);
      chk("idle_ready", 32'(load_ready), 32'h0);
      chk("fetch_addr", 32'(mem_addr), 32'(w));
      tick;
      chk("fetch_valid", 32'(fetch_valid), 32'(req));
      if (req) begin
         last_instr = (pc[1:0] != 2'b00) ? NOP : ref_mem[w];
         chk("fetch_misalign", 32'(fetch_misalign), 32'(pc[1:0] != 2'b00));
      end
      chk("fetch_instr", fetch_instr, last_instr);
      fetch_req  = 1'b0;
      load_valid = 1'b0;
   endtask

   // full load sequence; abort_at>=0 pulls reset before that many bytes are accepted
   task automatic do_load(input int nwords, input bit with_fetch, input int abort_at, input bit seq);
      int nbytes;
      int k;
      bit gap;
      logic [7:0] d;
      nbytes     = ((nwords > DEPTH) ? DEPTH : nwords) * 4;
      load_start = 1'b1;
      load_words = 9'(nwords);
      fetch_req  = with_fetch;
      fetch_pc   = $urandom;
      load_valid = 1'b0;
      tick;
      load_start = 1'b0;
      load_words = 9'($urandom);
      fetch_req  = 1'b0;
      chk("start_drop_fetch", 32'(fetch_valid), 32'h0);
      chk("start_busy", 32'(busy), 32'h1);
      if (nbytes == 0) begin
         chk("zero_done", 32'(load_done), 32'h1);
         chk("zero_ready", 32'(load_ready), 32'h0);
         chk("zero_we", 32'(mem_we), 32'h0);
         tick;
         chk("zero_done_end", 32'(load_done), 32'h0);
         chk("zero_busy_end", 32'(busy), 32'h0);
         return;
      end
      k = 0;
      while (k < nbytes) begin
         if (k == abort_at) begin
            rst_n = 1'b0;
            #1;
            chk("abort_busy", 32'(busy), 32'h0);
            chk("abort_ready", 32'(load_ready), 32'h0);
            chk("abort_we", 32'(mem_we), 32'h0);
            tick;
            rst_n      = 1'b1;
            load_valid = 1'b0;
            load_start = 1'b0;
            fetch_req  = 1'b0;
            last_instr = 32'h0;
            tick;
            return;
         end
         gap        = ($urandom_range(0, 2) == 0);
         d          = seq ? 8'(8'h11 * (k + 1)) : 8'($urandom);
         load_valid = !gap;
         load_data  = d;
         load_start = 1'($urandom);
         fetch_req  = 1'($urandom);
         fetch_pc   = $urandom;
         #1;
         chk("load_ready", 32'(load_ready), 32'h1);
         chk("load_done_early", 32'(load_done), 32'h0);
         if (gap) begin
            chk("gap_we", 32'(mem_we), 32'h0);
         end else begin
            chk("load_we", 32'(mem_we), 32'(1 << (k % 4)));
            chk("load_addr", 32'(mem_addr), 32'(k / 4));
            chk("load_wdata", 32'(mem_wdata), 32'(d));
         end
         tick;
         chk("load_fetch_valid", 32'(fetch_valid), 32'h0);
         if (!gap) begin
            ref_mem[k / 4][8 * (k % 4) +: 8] = d;
            k++;
         end
      end
      load_valid = 1'b0;
      load_start = 1'b0;
      fetch_req  = 1'b0;
      chk("done_pulse", 32'(load_done), 32'h1);
      chk("done_ready", 32'(load_ready), 32'h0);
      chk("done_busy", 32'(busy), 32'h1);
      tick;
      chk("done_end", 32'(load_done), 32'h0);
      chk("idle_busy", 32'(busy), 32'h0);
   endtask

   initial begin
      for (int w = 0; w < DEPTH; w++) begin
         ref_mem[w] = (w == 0) ? 32'hDEAD_BEEF : $urandom;
         for (int n = 0; n < 4; n++) bmem[n][w] = ref_mem[w][8 * n +: 8];
      end
      rst_n = 1'b0; load_start = 1'b0; load_words = '0; load_valid = 1'b0;
      load_data = '0; fetch_req = 1'b0; fetch_pc = '0;
      last_instr = 32'h0;
      tick; tick;
      chk("rst_fetch_valid", 32'(fetch_valid), 32'h0);
      chk("rst_fetch_instr", fetch_instr, 32'h0);
      chk("rst_misalign", 32'(fetch_misalign), 32'h0);
      chk("rst_load_done", 32'(load_done), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_load_ready", 32'(load_ready), 32'h0);
      rst_n = 1'b1;
      tick;

      do_fetch(32'h0, 1'b1);
      chk("deadbeef", fetch_instr, 32'hDEAD_BEEF);

      do_load(2, 1'b0, -1, 1'b1);
      do_fetch(32'h0, 1'b1);
      chk("word0_le", fetch_instr, 32'h4433_2211);
      do_fetch(32'h4, 1'b1);
      chk("word1_le", fetch_instr, 32'h8877_6655);

      do_fetch(32'h6, 1'b1);
      chk("misalign_nop", fetch_instr, NOP);
      do_fetch(32'h8, 1'b0);

      do_load(2, 1'b1, 5, 1'b0);
      do_load(2, 1'b1, -1, 1'b0);
      do_load(0, 1'b1, -1, 1'b0);
      do_load(300, 1'b0, -1, 1'b0);

      for (int i = 0; i < 3; i++) begin
         do_load($urandom_range(1, 20), 1'($urandom), -1, 1'b0);
         for (int j = 0; j < 20; j++) do_fetch($urandom, ($urandom_range(0, 3) != 0));
      end
      for (int j = 0; j < 40; j++) do_fetch($urandom, ($urandom_range(0, 3) != 0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
